// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// default bus widths and the SRAM control levels used when no access is active.
package dmem_pkg;

   localparam int DMEM_ADDR_W = 7;
   localparam int DMEM_DATA_W = 32;

   // Idle levels of the active-low SRAM controls.
   localparam logic SRAM_CEN_IDLE = 1'b1;
   localparam logic SRAM_WEN_IDLE = 1'b1;
   localparam logic SRAM_OEN_IDLE = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } dmem_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. Purely combinational; the caller stores
// last_grant and updates it whenever a grant is actually consumed.
module rr_arb2
   import dmem_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   // Pick the single requester, or on contention the port that did not win last time.
   always_comb begin
      gnt    = 2'b00;
      gnt_id = 1'b0;
      case (req)
         2'b01: begin
            gnt    = 2'b01;
            gnt_id = 1'b0;
         end
         2'b10: begin
            gnt    = 2'b10;
            gnt_id = 1'b1;
         end
         2'b11: begin
            if (last_grant) begin
               gnt    = 2'b01;
               gnt_id = 1'b0;
            end else begin
               gnt    = 2'b10;
               gnt_id = 1'b1;
            end
         end
         default: begin
            gnt    = 2'b00;
            gnt_id = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data SRAM between the CPU load/store port (port 0)
// and the DMA/loader port (port 1). Each access runs IDLE -> ACCESS ->
// [WAIT] -> RESP -> IDLE with registered SRAM controls; one response pulse
// goes back to the port that was granted.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DATA_W = DMEM_DATA_W,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_valid,
   output logic              p0_ready,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_rsp_valid,
   input  logic              p1_valid,
   output logic              p1_ready,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              CEN,
   output logic              WEN,
   output logic              OEN,
   output logic [ADDR_W-1:0] A,
   output logic [DATA_W-1:0] Data2Mem,
   input  logic [DATA_W-1:0] ReadDataMem
);

   // Reads with more than one cycle of SRAM latency pass through WAIT,
   // which lasts RD_LAT-1 cycles driven by a down-counter loaded with RD_LAT-2.
   localparam bit         RD_HAS_WAIT = (RD_LAT > 32'sd1);
   localparam int         CNT_LOAD_I  = (RD_LAT > 32'sd1) ? (RD_LAT - 32'sd2) : 32'sd0;
   localparam logic [1:0] CNT_LOAD    = CNT_LOAD_I[1:0];

   dmem_state_e       r_state;
   dmem_state_e       w_next;
   logic [1:0]        r_cnt;
   logic              r_last_grant;
   logic              r_we;
   logic              r_id;
   logic              r_cen;
   logic              r_wen;
   logic              r_oen;
   logic [ADDR_W-1:0] r_a;
   logic [DATA_W-1:0] r_d2m;
   logic [DATA_W-1:0] r_rdata;
   logic              r_p0_rsp;
   logic              r_p1_rsp;
   logic              r_busy;

   logic [1:0]        w_gnt;
   logic              w_gnt_id;
   logic              w_p0_ready;
   logic              w_p1_ready;
   logic              w_hs;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic              w_enter_resp;

   rr_arb2 u_rr_arb2 (
      .req        ({p1_valid, p0_valid}),
      .last_grant (r_last_grant),
      .gnt        (w_gnt),
      .gnt_id     (w_gnt_id)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_hs) begin
               w_next = ACCESS;
            end else begin
               w_next = IDLE;
            end
         end
         ACCESS: begin
            if (!r_we && RD_HAS_WAIT) begin
               w_next = WAIT;
            end else begin
               w_next = RESP;
            end
         end
         WAIT: begin
            if (r_cnt == 2'd0) begin
               w_next = RESP;
            end else begin
               w_next = WAIT;
            end
         end
         RESP: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Output logic: ready only in IDLE, only to the granted port, never during reset.
   always_comb begin
      w_p0_ready = 1'b0;
      w_p1_ready = 1'b0;
      if ((r_state == IDLE) && !rst_n) begin
         w_p0_ready = w_gnt[0];
         w_p1_ready = w_gnt[1];
      end else begin
         w_p0_ready = 1'b0;
         w_p1_ready = 1'b0;
      end
   end

   assign w_hs         = w_p0_ready | w_p1_ready;
   assign w_enter_resp = (w_next == RESP) && (r_state != RESP);

   // Steer the granted port's request fields toward the capture registers.
   always_comb begin
      w_sel_we    = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      if (w_gnt_id) begin
         w_sel_we    = p1_we;
         w_sel_addr  = p1_addr;
         w_sel_wdata = p1_wdata;
      end else begin
         w_sel_we    = p0_we;
         w_sel_addr  = p0_addr;
         w_sel_wdata = p0_wdata;
      end
   end

   // Remember who was served and what kind of access it was; track fairness.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_last_grant <= 1'b1;
         r_we         <= 1'b0;
         r_id         <= 1'b0;
      end else if (w_hs) begin
         r_last_grant <= w_gnt_id;
         r_we         <= w_sel_we;
         r_id         <= w_gnt_id;
      end
   end

   // WAIT down-counter: loaded when a read leaves ACCESS, decremented while waiting.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_cnt <= 2'd0;
      end else if ((r_state == ACCESS) && (w_next == WAIT)) begin
         r_cnt <= CNT_LOAD;
      end else if ((r_state == WAIT) && (r_cnt != 2'd0)) begin
         r_cnt <= r_cnt - 2'd1;
      end
   end

   // SRAM controls: active only in the single cycle after a handshake (ACCESS);
   // address and write data are held afterwards.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_cen <= SRAM_CEN_IDLE;
         r_wen <= SRAM_WEN_IDLE;
         r_oen <= SRAM_OEN_IDLE;
         r_a   <= '0;
         r_d2m <= '0;
      end else if (w_hs) begin
         r_cen <= 1'b0;
         r_wen <= ~w_sel_we;
         r_oen <= w_sel_we;
         r_a   <= w_sel_addr;
         if (w_sel_we) begin
            r_d2m <= w_sel_wdata;
         end
      end else begin
         r_cen <= SRAM_CEN_IDLE;
         r_wen <= SRAM_WEN_IDLE;
         r_oen <= SRAM_OEN_IDLE;
      end
   end

   // Response: one-cycle pulse to the served port; read data captured on the RESP entry edge.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_p0_rsp <= 1'b0;
         r_p1_rsp <= 1'b0;
         r_rdata  <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_p0_rsp <= w_enter_resp && !r_id;
         r_p1_rsp <= w_enter_resp && r_id;
         r_busy   <= (w_next != IDLE);
         if (w_enter_resp && !r_we) begin
            r_rdata <= ReadDataMem;
         end
      end
   end

   assign p0_ready     = w_p0_ready;
   assign p1_ready     = w_p1_ready;
   assign p0_rsp_valid = r_p0_rsp;
   assign p1_rsp_valid = r_p1_rsp;
   assign rsp_rdata    = r_rdata;
   assign busy         = r_busy;
   assign CEN          = r_cen;
   assign WEN          = r_wen;
   assign OEN          = r_oen;
   assign A            = r_a;
   assign Data2Mem     = r_d2m;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter (RD_LAT = 3). A transaction-level
// reference model predicts grants, SRAM access cycles and responses; a
// monitor on the falling edge compares the DUT against the queued expectations.
module tb_dmem_arbiter;

   localparam int AW     = 7;
   localparam int DW     = 32;
   localparam int RD_LAT = 3;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } req_t;

   typedef struct {
      int            cyc;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } acc_t;

   typedef struct {
      int            cyc;
      int            port;
      logic          we;
      logic [DW-1:0] data;
   } rsp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [1:0]    tb_v;
   logic [1:0]    tb_we;
   logic [AW-1:0] tb_addr [2];
   logic [DW-1:0] tb_wd   [2];
   logic          p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, busy;
   logic [DW-1:0] rsp_rdata, Data2Mem, ReadDataMem;
   logic          CEN, WEN, OEN;
   logic [AW-1:0] A;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_valid(tb_v[0]), .p0_ready(p0_ready), .p0_we(tb_we[0]),
      .p0_addr(tb_addr[0]), .p0_wdata(tb_wd[0]), .p0_rsp_valid(p0_rsp_valid),
      .p1_valid(tb_v[1]), .p1_ready(p1_ready), .p1_we(tb_we[1]),
      .p1_addr(tb_addr[1]), .p1_wdata(tb_wd[1]), .p1_rsp_valid(p1_rsp_valid),
      .rsp_rdata(rsp_rdata), .busy(busy),
      .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem),
      .ReadDataMem(ReadDataMem)
   );

   function automatic logic [DW-1:0] init_val(input int i);
      return 32'h5A00_0000 ^ (i * 32'h0001_0003);
   endfunction

   // ---------------- SRAM model with RD_LAT cycles of read latency ----------------
   logic [DW-1:0] sram [0:(1<<AW)-1];
   logic [DW-1:0] rd0;
   logic [DW-1:0] rd_pipe [0:RD_LAT-2];
   bit            mem_init;

   always_comb begin
      if (!CEN && WEN && !OEN) rd0 = sram[A];
      else                     rd0 = 32'hBAD0_0000 | {25'd0, A};
   end

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < (1 << AW); i++) sram[i] <= init_val(i);
         mem_init <= 1'b1;
      end else if (!CEN && !WEN) begin
         sram[A] <= Data2Mem;
      end
      rd_pipe[0] <= rd0;
      for (int i = 1; i < RD_LAT - 1; i++) rd_pipe[i] <= rd_pipe[i-1];
   end

   assign ReadDataMem = rd_pipe[RD_LAT-2];

   // ---------------- bookkeeping ----------------
   int cyc;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_cmp, n_fail;
   bit   chk_en;
   int   acc_cnt [2];
   acc_t acc_q[$];
   rsp_t rsp_q[$];
   int   m_free;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
      end
   endtask

   // ---------------- reference model + monitor ----------------
   initial begin : monitor
      logic [DW-1:0] ref_mem [0:(1<<AW)-1];
      logic          m_last;
      logic [DW-1:0] m_rd;
      logic          rst_prev;
      logic [1:0]    e_gnt;
      int            g;
      acc_t          a;
      rsp_t          r;
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
      m_free   = 0;
      m_last   = 1'b1;
      m_rd     = '0;
      rst_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            // grant prediction: only when idle and out of reset
            e_gnt = 2'b00;
            if (!rst_n && (cyc >= m_free)) begin
               case (tb_v)
                  2'b01:   e_gnt = 2'b01;
                  2'b10:   e_gnt = 2'b10;
                  2'b11:   e_gnt = m_last ? 2'b01 : 2'b10;
                  default: e_gnt = 2'b00;
               endcase
            end
            chk("p0_ready", {31'd0, p0_ready}, {31'd0, e_gnt[0]});
            chk("p1_ready", {31'd0, p1_ready}, {31'd0, e_gnt[1]});
            chk("busy", {31'd0, busy}, {31'd0, (cyc < m_free)});
            if (rst_prev) begin
               chk("rst_A", {25'd0, A}, 32'd0);
               chk("rst_Data2Mem", Data2Mem, 32'd0);
               chk("rst_rdata", rsp_rdata, 32'd0);
            end
            // SRAM pins
            if (acc_q.size() > 0 && acc_q[0].cyc == cyc) begin
               a = acc_q.pop_front();
               chk("acc_CEN", {31'd0, CEN}, 32'd0);
               chk("acc_WEN", {31'd0, WEN}, {31'd0, ~a.we});
               chk("acc_OEN", {31'd0, OEN}, {31'd0, a.we});
               chk("acc_A", {25'd0, A}, {25'd0, a.addr});
               if (a.we) chk("acc_Data2Mem", Data2Mem, a.data);
            end else begin
               chk("idle_CEN", {31'd0, CEN}, 32'd1);
               chk("idle_WEN", {31'd0, WEN}, 32'd1);
               chk("idle_OEN", {31'd0, OEN}, 32'd1);
            end
            // responses
            if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
               r = rsp_q.pop_front();
               chk("rsp_valid0", {31'd0, p0_rsp_valid}, {31'd0, (r.port == 0)});
               chk("rsp_valid1", {31'd0, p1_rsp_valid}, {31'd0, (r.port == 1)});
               if (r.we) begin
                  chk("wr_rdata_hold", rsp_rdata, m_rd);
               end else begin
                  chk("rd_rdata", rsp_rdata, r.data);
                  m_rd = r.data;
               end
            end else begin
               chk("no_rsp0", {31'd0, p0_rsp_valid}, 32'd0);
               chk("no_rsp1", {31'd0, p1_rsp_valid}, 32'd0);
            end
            // advance the model
            if (rst_n) begin
               acc_q.delete();
               rsp_q.delete();
               m_free = 0;
               m_last = 1'b1;
               m_rd   = '0;
            end else if (e_gnt != 2'b00) begin
               g = e_gnt[1] ? 1 : 0;
               acc_cnt[g]++;
               m_last = e_gnt[1];
               m_free = cyc + (tb_we[g] ? 3 : 2 + RD_LAT);
               acc_q.push_back('{cyc + 1, tb_we[g], tb_addr[g], tb_wd[g]});
               rsp_q.push_back('{cyc + (tb_we[g] ? 2 : 1 + RD_LAT), g, tb_we[g],
                                 tb_we[g] ? 32'd0 : ref_mem[tb_addr[g]]});
               if (tb_we[g]) ref_mem[tb_addr[g]] = tb_wd[g];
            end
         end
         rst_prev = rst_n;
      end
   end

   // ---------------- stimulus ----------------
   req_t req_q0[$];
   req_t req_q1[$];
   req_t cur [2];
   bit   act [2];
   int   seen [2];

   task automatic step();
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
         if (act[p] && acc_cnt[p] != seen[p]) begin
            seen[p] = acc_cnt[p];
            act[p]  = 1'b0;
         end
         if (!act[p]) begin
            if (p == 0 && req_q0.size() > 0) begin
               cur[p] = req_q0.pop_front();
               act[p] = 1'b1;
            end else if (p == 1 && req_q1.size() > 0) begin
               cur[p] = req_q1.pop_front();
               act[p] = 1'b1;
            end
         end
         tb_v[p]    = act[p];
         tb_we[p]   = cur[p].we;
         tb_addr[p] = cur[p].addr;
         tb_wd[p]   = cur[p].data;
      end
   endtask

   task automatic push(input int p, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
      req_t q;
      q.we = we; q.addr = ad; q.data = d;
      if (p == 0) req_q0.push_back(q);
      else        req_q1.push_back(q);
   endtask

   task automatic wait_drain(input int budget);
      int k;
      k = 0;
      while ((req_q0.size() > 0 || req_q1.size() > 0 || act[0] || act[1] ||
              acc_q.size() > 0 || rsp_q.size() > 0 || cyc < m_free + 1) && k < budget) begin
         step();
         k++;
      end
      if (k >= budget) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain_timeout cyc=%0d got=busy exp=idle", cyc);
      end
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b1;
      repeat (n) step();
      rst_n = 1'b0;
   endtask

   initial begin : stim
      int k;
      int sel;
      logic [AW-1:0] ad;
      rst_n = 1'b1;
      tb_v  = 2'b00;
      tb_we = 2'b00;
      for (int p = 0; p < 2; p++) begin
         tb_addr[p] = '0;
         tb_wd[p]   = '0;
         cur[p]     = '{1'b0, '0, '0};
      end
      repeat (3) step();
      chk_en = 1'b1;
      repeat (2) step();
      rst_n = 1'b0;

      // write then read back on port 0
      push(0, 1'b1, 7'd5, 32'hDEAD_BEEF);
      wait_drain(50);
      push(0, 1'b0, 7'd5, 32'h0);
      wait_drain(50);

      // contention straight out of reset: p0 first, then alternate
      do_reset(2);
      for (int i = 0; i < 4; i++) begin
         push(0, i[0], 7'(10 + i), $urandom);
         push(1, ~i[0], 7'(20 + i), $urandom);
      end
      wait_drain(200);

      // top address on port 1, read of the initial contents and after a write
      push(1, 1'b0, 7'd127, 32'h0);
      wait_drain(50);
      push(1, 1'b1, 7'd127, 32'h1234_5678);
      push(1, 1'b0, 7'd127, 32'h0);
      push(0, 1'b0, 7'd0, 32'h0);
      wait_drain(100);

      // reset while a read is in WAIT, then contention grants p0 first
      push(0, 1'b0, 7'd5, 32'h0);
      k = 0;
      while (!(rsp_q.size() > 0 && acc_q.size() == 0) && k < 50) begin
         step();
         k++;
      end
      if (k >= 50) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_state_timeout cyc=%0d got=none exp=read_in_wait", cyc);
      end
      do_reset(2);
      push(0, 1'b0, 7'd5, 32'h0);
      push(1, 1'b1, 7'd6, 32'hCAFE_F00D);
      push(0, 1'b1, 7'd7, 32'h0BAD_CAFE);
      wait_drain(100);

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (!act[p] && ((p == 0) ? req_q0.size() : req_q1.size()) == 0 &&
                $urandom_range(0, 2) == 0) begin
               sel = $urandom_range(0, 3);
               case (sel)
                  0:       ad = 7'd0;
                  1:       ad = 7'd127;
                  2:       ad = 7'd5;
                  default: ad = 7'($urandom);
               endcase
               push(p, 1'($urandom), ad, $urandom);
            end
         end
         step();
      end
      wait_drain(200);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
